// File: rtl/dac_2ch_sched_pkg.sv
// Shared types and constants for the two-channel DAC sample scheduler.
// Holds the FSM encoding, sample/command widths and the command-word builder.
package dac_2ch_sched_pkg;

    localparam int unsigned DW        = 12;
    localparam int unsigned DIV_W     = 16;
    localparam int unsigned WORD_W    = 16;
    localparam int unsigned CHSEL_BIT = 15;

    localparam logic GA_BIT   = 1'b1;
    localparam logic SHDN_BIT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // DAC command word: {chsel, 0, GA, SHDN, data}
    function automatic logic [WORD_W-1:0] make_word(input logic chsel, input logic [DW-1:0] data);
        logic [WORD_W-1:0] w;
        w            = {1'b0, 1'b0, GA_BIT, SHDN_BIT, data};
        w[CHSEL_BIT] = chsel;
        return w;
    endfunction

endpackage

// File: rtl/dac_2ch_sched_if.sv
// Sample-source and SPI-engine handshake bundle for the DAC scheduler.
// The master modport is the scheduler; the slave modport is its environment.
interface dac_2ch_sched_if;
    import dac_2ch_sched_pkg::*;

    logic              ch0_req_i;
    logic [DW-1:0]     ch0_data_i;
    logic              ch0_ack_o;
    logic              ch1_req_i;
    logic [DW-1:0]     ch1_data_i;
    logic              ch1_ack_o;
    logic              spi_sts_o;
    logic [WORD_W-1:0] spi_word_o;
    logic              spi_end_i;

    modport master (
        input  ch0_req_i, ch0_data_i, ch1_req_i, ch1_data_i, spi_end_i,
        output ch0_ack_o, ch1_ack_o, spi_sts_o, spi_word_o
    );

    modport slave (
        output ch0_req_i, ch0_data_i, ch1_req_i, ch1_data_i, spi_end_i,
        input  ch0_ack_o, ch1_ack_o, spi_sts_o, spi_word_o
    );

endinterface

// File: rtl/dac_2ch_sched_sample_tick.sv
// Programmable sample-period counter producing a one-cycle tick every max(period_i,2) cycles.
// The period is re-sampled at each wrap and continuously while disabled.
module dac_2ch_sched_sample_tick
    import dac_2ch_sched_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] period_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] last_q;
    logic [DIV_W-1:0] last_c;

    // Terminal count P-1, with periods below 2 clamped to 2
    assign last_c = (period_i < DIV_W'(2)) ? DIV_W'(1) : period_i - DIV_W'(1);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q  <= '0;
            last_q <= last_c;
            tick_o <= 1'b0;
        end else begin
            tick_o <= 1'b0;
            if (!en_i) begin
                cnt_q  <= '0;
                last_q <= last_c;
            end else if (cnt_q >= last_q) begin
                cnt_q  <= '0;
                last_q <= last_c;
                tick_o <= 1'b1;
            end else begin
                cnt_q <= cnt_q + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/dac_2ch_sched.sv
// Two-channel DAC sample scheduler: per-channel holding registers plus a frame FSM
// that issues one SPI write per pending channel (ch0 first) on every sample tick.
module dac_2ch_sched
    import dac_2ch_sched_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   en_i,
    input  logic [DIV_W-1:0]       period_i,
    dac_2ch_sched_if.master        bus,
    output logic                   tick_o,
    output logic                   busy_o,
    output logic                   ovr_o
);

    state_t            state_q;
    logic [1:0]        mask_q;
    logic              valid0_q;
    logic              valid1_q;
    logic [DW-1:0]     data0_q;
    logic [DW-1:0]     data1_q;
    logic              sts_q;
    logic [WORD_W-1:0] word_q;
    logic              ovr_q;

    dac_2ch_sched_sample_tick u_tick (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .en_i     (en_i),
        .period_i (period_i),
        .tick_o   (tick_o)
    );

    assign bus.ch0_ack_o  = bus.ch0_req_i & ~valid0_q;
    assign bus.ch1_ack_o  = bus.ch1_req_i & ~valid1_q;
    assign bus.spi_sts_o  = sts_q;
    assign bus.spi_word_o = word_q;
    assign busy_o         = (state_q != ST_IDLE);
    assign ovr_o          = ovr_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            mask_q   <= 2'b00;
            valid0_q <= 1'b0;
            valid1_q <= 1'b0;
            data0_q  <= '0;
            data1_q  <= '0;
            sts_q    <= 1'b0;
            word_q   <= '0;
            ovr_q    <= 1'b0;
        end else begin
            sts_q <= 1'b0;

            if (bus.ch0_ack_o) begin
                data0_q  <= bus.ch0_data_i;
                valid0_q <= 1'b1;
            end
            if (bus.ch1_ack_o) begin
                data1_q  <= bus.ch1_data_i;
                valid1_q <= 1'b1;
            end

            if (!en_i) begin
                ovr_q <= 1'b0;
            end else if (tick_o && busy_o) begin
                ovr_q <= 1'b1;
            end

            // Word and strobe are loaded on entry so SEND is exactly the strobe cycle
            unique case (state_q)
                ST_IDLE: begin
                    if (tick_o && en_i) begin
                        mask_q <= {valid1_q, valid0_q};
                        if (valid0_q || valid1_q) begin
                            state_q <= ST_SEND;
                            sts_q   <= 1'b1;
                            word_q  <= valid0_q ? make_word(1'b0, data0_q)
                                                : make_word(1'b1, data1_q);
                        end
                    end
                end
                ST_SEND: begin
                    if (mask_q[0]) begin
                        valid0_q  <= 1'b0;
                        mask_q[0] <= 1'b0;
                    end else begin
                        valid1_q  <= 1'b0;
                        mask_q[1] <= 1'b0;
                    end
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.spi_end_i) begin
                        if (mask_q != 2'b00) begin
                            state_q <= ST_SEND;
                            sts_q   <= 1'b1;
                            word_q  <= mask_q[0] ? make_word(1'b0, data0_q)
                                                 : make_word(1'b1, data1_q);
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_2ch_sched.sv
// Directed self-checking bench for dac_2ch_sched with a simple SPI-engine model
// that answers each start strobe with an end pulse end_dly cycles later.
module tb_dac_2ch_sched;
    import dac_2ch_sched_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [DIV_W-1:0] period;
    logic             tick;
    logic             busy;
    logic             ovr;

    dac_2ch_sched_if bus ();

    dac_2ch_sched dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .en_i     (en),
        .period_i (period),
        .bus      (bus),
        .tick_o   (tick),
        .busy_o   (busy),
        .ovr_o    (ovr)
    );

    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Event log sampled on the falling edge
    int          cyc = 0;
    int          tick_cyc[$];
    int          sts_cyc[$];
    int          end_cyc[$];
    logic [15:0] sts_word[$];
    int          n_busy = 0;
    int          n_ack0 = 0;
    int          n_ack1 = 0;
    int          b_tick, b_sts, b_end, b_busy, b_ack0, b_ack1;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (tick)          tick_cyc.push_back(cyc);
        if (bus.spi_sts_o) begin
            sts_cyc.push_back(cyc);
            sts_word.push_back(bus.spi_word_o);
        end
        if (bus.spi_end_i) end_cyc.push_back(cyc);
        if (busy)          n_busy++;
        if (bus.ch0_ack_o) n_ack0++;
        if (bus.ch1_ack_o) n_ack1++;
    end

    task automatic mark();
        b_tick = tick_cyc.size();
        b_sts  = sts_cyc.size();
        b_end  = end_cyc.size();
        b_busy = n_busy;
        b_ack0 = n_ack0;
        b_ack1 = n_ack1;
    endtask

    function automatic int qget(input int q[$], input int idx);
        return (idx < q.size()) ? q[idx] : -1000;
    endfunction

    function automatic logic [15:0] wget(input int idx);
        return (idx < sts_word.size()) ? sts_word[idx] : 16'hxxxx;
    endfunction

    // SPI engine model; aborts a pending end pulse if reset is seen
    int   end_dly  = 10;
    logic eng_busy = 1'b0;

    initial begin
        bit abort;
        bus.spi_end_i = 1'b0;
        forever begin
            @(posedge clk); #2;
            bus.spi_end_i = 1'b0;
            if (rst && bus.spi_sts_o) begin
                abort    = 1'b0;
                eng_busy = 1'b1;
                for (int k = 0; k < end_dly; k++) begin
                    @(posedge clk); #2;
                    if (!rst) abort = 1'b1;
                end
                if (!abort) bus.spi_end_i = 1'b1;
                eng_busy = 1'b0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic offer(input int ch, input logic [DW-1:0] d);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            if (ch == 0) begin
                bus.ch0_req_i = 1'b1; bus.ch0_data_i = d;
            end else begin
                bus.ch1_req_i = 1'b1; bus.ch1_data_i = d;
            end
            #1;
            got = (ch == 0) ? bus.ch0_ack_o : bus.ch1_ack_o;
            @(posedge clk); #1;
        end
        if (ch == 0) bus.ch0_req_i = 1'b0;
        else         bus.ch1_req_i = 1'b0;
        chk("offer_ack", 32'(got), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            if (!busy && !eng_busy) done = 1'b1;
            else step(1);
        end
        chk(tag, 32'(done), 32'd1);
    endtask

    task automatic wait_sts(input string tag, input int n, input int bound);
        for (int k = 0; k < bound && (sts_cyc.size() - b_sts) < n; k++) step(1);
        chk(tag, 32'(sts_cyc.size() - b_sts), 32'(n));
    endtask

    // Both holding registers empty <=> both acks follow their requests
    task automatic probe_empty(input string tag);
        bus.ch0_req_i = 1'b1;
        bus.ch1_req_i = 1'b1;
        #1;
        chk({tag, "_ack0"}, 32'(bus.ch0_ack_o), 32'd1);
        chk({tag, "_ack1"}, 32'(bus.ch1_ack_o), 32'd1);
        bus.ch0_req_i = 1'b0;
        bus.ch1_req_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; en = 1'b0; period = DIV_W'(20);
        bus.ch0_req_i = 1'b0; bus.ch0_data_i = '0;
        bus.ch1_req_i = 1'b0; bus.ch1_data_i = '0;

        // Reset state
        step(3);
        chk("rst_word", 32'(bus.spi_word_o), 32'h0);
        chk("rst_sts",  32'(bus.spi_sts_o),  32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ovr",  32'(ovr),  32'h0);
        chk("rst_tick", 32'(tick), 32'h0);
        rst = 1'b1;
        step(1);

        // Basic two-channel frame
        end_dly = 10;
        mark();
        offer(0, 12'h800);
        offer(1, 12'h3FF);
        en = 1'b1;
        wait_sts("basic_nsts", 2, 200);
        wait_idle("basic_idle");
        chk("basic_w0",   32'(wget(b_sts)),     32'h3800);
        chk("basic_w1",   32'(wget(b_sts + 1)), 32'hB3FF);
        chk("basic_lat0", 32'(qget(sts_cyc, b_sts) - qget(tick_cyc, b_tick)), 32'd1);
        chk("basic_lat1", 32'(qget(sts_cyc, b_sts + 1) - qget(end_cyc, b_end)), 32'd1);
        chk("basic_busy", 32'(busy), 32'd0);
        probe_empty("basic_empty");

        // Single channel pending
        mark();
        offer(1, 12'h001);
        step(50);
        wait_idle("single_idle");
        chk("single_nsts", 32'(sts_cyc.size() - b_sts), 32'd1);
        chk("single_w",    32'(wget(b_sts)), 32'hB001);
        chk("single_ack0", 32'(n_ack0 - b_ack0), 32'd0);
        chk("single_ack1", 32'(n_ack1 - b_ack1), 32'd1);

        // Empty ticks
        mark();
        step(100);
        chk("empty_ntick",  32'(tick_cyc.size() - b_tick), 32'd5);
        chk("empty_period", 32'(qget(tick_cyc, b_tick + 1) - qget(tick_cyc, b_tick)), 32'd20);
        chk("empty_nsts",   32'(sts_cyc.size() - b_sts), 32'd0);
        chk("empty_busy",   32'(n_busy - b_busy), 32'd0);

        // Overrun with short period and slow engine
        en = 1'b0;
        period = DIV_W'(2);
        end_dly = 30;
        step(1);
        mark();
        offer(0, 12'h123);
        en = 1'b1;
        wait_sts("ovr_sts", 1, 20);
        chk("ovr_before", 32'(ovr), 32'd0);
        step(4);
        chk("ovr_set", 32'(ovr), 32'd1);
        chk("ovr_w",   32'(wget(b_sts)), 32'h3123);
        period = DIV_W'(0);
        step(4);
        mark();
        step(20);
        chk("ovr_p0_ntick", 32'(tick_cyc.size() - b_tick), 32'd10);
        wait_idle("ovr_idle");
        step(10);
        chk("ovr_sticky", 32'(ovr), 32'd1);
        en = 1'b0;
        step(1);
        en = 1'b1;
        chk("ovr_clr", 32'(ovr), 32'd0);
        mark();
        step(10);
        chk("ovr_stay_clr", 32'(ovr), 32'd0);
        chk("ovr_no_sts",   32'(sts_cyc.size() - b_sts), 32'd0);

        // Handshake backpressure on ch0
        en = 1'b0;
        period = DIV_W'(20);
        end_dly = 10;
        step(1);
        mark();
        bus.ch0_req_i = 1'b1;
        bus.ch0_data_i = 12'hAAA;
        #1;
        chk("bp_ack_first", 32'(bus.ch0_ack_o), 32'd1);
        step(1);
        bus.ch0_data_i = 12'h555;
        #1;
        chk("bp_ack_held", 32'(bus.ch0_ack_o), 32'd0);
        en = 1'b1;
        for (int k = 0; k < 60 && !bus.spi_sts_o; k++) step(1);
        chk("bp_sts_seen",  32'(bus.spi_sts_o), 32'd1);
        chk("bp_ack_send",  32'(bus.ch0_ack_o), 32'd0);
        chk("bp_w0",        32'(bus.spi_word_o), 32'h3AAA);
        step(1);
        chk("bp_ack_after", 32'(bus.ch0_ack_o), 32'd1);
        step(1);
        bus.ch0_req_i = 1'b0;
        chk("bp_ack_count", 32'(n_ack0 - b_ack0), 32'd2);
        wait_idle("bp_idle");
        mark();
        wait_sts("bp_sts2", 1, 60);
        chk("bp_w1", 32'(wget(b_sts)), 32'h3555);
        wait_idle("bp_idle2");

        // Reset during WAIT
        mark();
        offer(0, 12'h111);
        offer(1, 12'h222);
        wait_sts("rstw_sts", 1, 60);
        step(3);
        chk("rstw_busy_pre", 32'(busy), 32'd1);
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        chk("rstw_busy", 32'(busy), 32'd0);
        chk("rstw_sts",  32'(bus.spi_sts_o), 32'd0);
        chk("rstw_word", 32'(bus.spi_word_o), 32'h0);
        chk("rstw_ovr",  32'(ovr), 32'd0);
        chk("rstw_tick", 32'(tick), 32'd0);
        probe_empty("rstw_empty");
        mark();
        step(50);
        chk("rstw_ntick", 32'(tick_cyc.size() - b_tick), 32'd2);
        chk("rstw_nsts",  32'(sts_cyc.size() - b_sts), 32'd0);
        chk("rstw_nend",  32'(end_cyc.size() - b_end), 32'd0);
        chk("rstw_nbusy", 32'(n_busy - b_busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
